pipe_credit_buf: RTL and testbench



---
 rtl/pipe_credit_pkg.sv | 10 +
 rtl/pipe_credit_fifo.sv | 78 +++++++
 rtl/pipe_credit_buf.sv | 118 +++++++++++
 tb/tb_pipe_credit_buf.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_credit_pkg.sv
// Shared types and constants for the pipe_credit_buf credit controller.
package pipe_credit_pkg;

  localparam int STALL_CNT_W = 32;

  typedef logic [STALL_CNT_W-1:0] stall_cnt_t;

  localparam stall_cnt_t STALL_CNT_MAX = '1;

endpackage : pipe_credit_pkg

// File: rtl/pipe_credit_fifo.sv
// Result FIFO for pipe_credit_buf: BUF_D-entry circular buffer with an
// occupancy counter and a combinational head-of-queue read.
module pipe_credit_fifo #(
  parameter int REG_W = 16,
  parameter int BUF_D = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [REG_W-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [REG_W-1:0]           rd_data,
  output logic [$clog2(BUF_D+1)-1:0] occ,
  output logic                       full,
  output logic                       empty
);

  localparam int CNT_W = $clog2(BUF_D + 1);
  localparam int PTR_W = $clog2(BUF_D);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_D - 1);
  localparam logic [CNT_W-1:0] OCC_FULL = CNT_W'(BUF_D);

  logic [REG_W-1:0] mem_q [BUF_D];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             do_wr;
  logic             do_rd;

  // Pointers wrap at BUF_D-1 so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (occ_q == OCC_FULL);
  assign empty   = (occ_q == '0);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem_q[rd_ptr_q];
  assign occ     = occ_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (do_wr) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (do_rd) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (do_wr && !do_rd) begin
      occ_d = occ_q + CNT_W'(1);
    end else if (!do_wr && do_rd) begin
      occ_d = occ_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage carries no reset; validity is tracked by occ_q alone.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule : pipe_credit_fifo

// File: rtl/pipe_credit_buf.sv
// Credit-based flow controller around a fixed-latency, non-stallable pipeline.
// Optional stall statistics: define PIPE_CREDIT_BUF_STATS_EN to add stall_cnt.
module pipe_credit_buf
  import pipe_credit_pkg::*;
#(
  parameter int REG_W = 16,
  parameter int PIP_D = 4,
  parameter int BUF_D = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [REG_W-1:0] s_data,
  output logic             iss_valid,
  output logic [REG_W-1:0] iss_data,
  input  logic             ret_valid,
  input  logic [REG_W-1:0] ret_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [REG_W-1:0] m_data,
`ifdef PIPE_CREDIT_BUF_STATS_EN
  output stall_cnt_t       stall_cnt,
`endif
  output logic             err
);

  localparam int CNT_W = $clog2(BUF_D + 1);

  if (PIP_D < 1 || BUF_D < 2) begin : g_bad_params
    $error("pipe_credit_buf: PIP_D must be >= 1 and BUF_D >= 2");
  end

  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] occ;
  logic [CNT_W:0]   credit_used;
  logic             fifo_full;
  logic             fifo_empty;
  logic             issue;
  logic             ret_ok;
  logic             ret_bad;
  logic             wr_en;
  logic             pop;
  logic             err_q, err_d;

  // Credits count both in-flight and buffered results, so s_ready depends
  // only on registers and a returning result always has a free slot.
  assign credit_used = {1'b0, inflight_q} + {1'b0, occ};
  assign s_ready     = (credit_used < (CNT_W + 1)'(BUF_D));
  assign issue       = s_valid & s_ready;
  assign iss_valid   = issue;
  assign iss_data    = s_data;

  assign ret_ok  = ret_valid & (inflight_q != '0);
  assign ret_bad = ret_valid & ((inflight_q == '0) | fifo_full);
  assign wr_en   = ret_ok & ~fifo_full;
  assign m_valid = ~fifo_empty;
  assign pop     = m_valid & m_ready;

  always_comb begin
    inflight_d = inflight_q;
    if (issue && !ret_ok) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (!issue && ret_ok) begin
      inflight_d = inflight_q - CNT_W'(1);
    end
    err_d = err_q | ret_bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign err = err_q;

  pipe_credit_fifo #(
    .REG_W (REG_W),
    .BUF_D (BUF_D)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (ret_data),
    .rd_en   (pop),
    .rd_data (m_data),
    .occ     (occ),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef PIPE_CREDIT_BUF_STATS_EN
  stall_cnt_t stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (s_valid && !s_ready && (stall_cnt_q != STALL_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule : pipe_credit_buf

// File: tb/tb_pipe_credit_buf.sv
// Scoreboard bench for pipe_credit_buf with an identity loopback pipeline.
module tb_pipe_credit_buf;

  localparam int REG_W = 16;
  localparam int PIP_D = 4;
  localparam int BUF_D = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             s_valid, s_ready;
  logic [REG_W-1:0] s_data;
  logic             iss_valid;
  logic [REG_W-1:0] iss_data;
  logic             ret_valid;
  logic [REG_W-1:0] ret_data;
  logic             m_valid, m_ready;
  logic [REG_W-1:0] m_data;
  logic             err;
`ifdef PIPE_CREDIT_BUF_STATS_EN
  logic [31:0]      stall_cnt;
`endif

  int compared = 0;
  int mismatched = 0;
  int pop_cnt = 0;
  logic [REG_W-1:0] sb [$];

  always #5 clk = ~clk;

  pipe_credit_buf #(
    .REG_W (REG_W),
    .PIP_D (PIP_D),
    .BUF_D (BUF_D)
  ) dut (
    .clk       (clk),
`ifdef PIPE_CREDIT_BUF_STATS_EN
    .stall_cnt (stall_cnt),
`endif
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .iss_valid (iss_valid),
    .iss_data  (iss_data),
    .ret_valid (ret_valid),
    .ret_data  (ret_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .err       (err)
  );

  // External pipeline model, reset by the same rst_n.
  logic [PIP_D-1:0] pv_q;
  logic [REG_W-1:0] pd_q [PIP_D];
  logic             spur_v;
  logic [REG_W-1:0] spur_d;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q <= '0;
    end else begin
      pv_q     <= {pv_q[PIP_D-2:0], iss_valid};
      pd_q[0]  <= iss_data;
      for (int k = 1; k < PIP_D; k++) pd_q[k] <= pd_q[k-1];
    end
  end

  assign ret_valid = pv_q[PIP_D-1] | spur_v;
  assign ret_data  = spur_v ? spur_d : pd_q[PIP_D-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: push on issue, pop-and-compare on every output handshake.
  always @(negedge clk) begin
    if (rst_n && iss_valid) sb.push_back(iss_data);
    if (rst_n && m_valid && m_ready) begin
      pop_cnt++;
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_pop: got 0x%04h, required no output", m_data);
      end else begin
        logic [REG_W-1:0] req;
        req = sb.pop_front();
        $display("pop %0d: m_data=0x%04h expected=0x%04h", pop_cnt, m_data, req);
        check("m_data_order", {16'h0, m_data}, {16'h0, req});
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    m_ready = 1'b1;
    s_valid = 1'b0;
    while ((sb.size() != 0 || m_valid) && n < 100) begin
      next_cycle();
      n++;
    end
    check("drain_in_time", {31'h0, (n < 100)}, 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int pop_base, n_iss, n_mv;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0; spur_v = 1'b0; spur_d = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_err", err, 0);
    check("rst_iss_valid", iss_valid, 0);

    // Single item: issue at cycle 0, return at 4, visible at 5.
    next_cycle();
    m_ready = 1'b1; s_valid = 1'b1; s_data = 16'h1234;
    @(negedge clk);
    check("single_iss_valid", iss_valid, 1);
    check("single_iss_data", iss_data, 32'h1234);
    next_cycle();
    s_valid = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    check("single_ret_c4", ret_valid, 1);
    check("single_mvalid_c4", m_valid, 0);
    next_cycle();
    @(negedge clk);
    check("single_mvalid_c5", m_valid, 1);
    check("single_mdata_c5", m_data, 32'h1234);
    next_cycle();

    // Streaming 32 items with m_ready=1.
    pop_base = pop_cnt;
    for (int i = 0; i < 32; i++) begin
      s_valid = 1'b1; s_data = 16'h0100 + 16'(i);
      @(negedge clk);
      check("stream_s_ready", s_ready, 1);
      next_cycle();
    end
    s_valid = 1'b0;
    repeat (4) next_cycle();
    check("stream_pops_c36", pop_cnt - pop_base, 31);
    next_cycle();
    check("stream_pops_c37", pop_cnt - pop_base, 32);
    drain();

    // Backpressure: credits run out after BUF_D issues.
    m_ready = 1'b0;
    n_iss = 0;
    for (int i = 0; i < 12; i++) begin
      s_valid = 1'b1; s_data = 16'h0200 + 16'(i);
      @(negedge clk);
      if (iss_valid) n_iss++;
      next_cycle();
    end
    check("bp_issue_count", n_iss, 6);
    m_ready = 1'b1; s_data = 16'h02FF;
    @(negedge clk);
    check("bp_occ_full", {29'h0, dut.u_fifo.occ_q}, 6);
    check("bp_s_ready_pop_cycle", s_ready, 0);
    check("bp_m_valid", m_valid, 1);
    next_cycle();
    @(negedge clk);
    check("bp_s_ready_after_pop", s_ready, 1);
    next_cycle();
    drain();

    // Spurious return with nothing in flight.
    m_ready = 1'b0; s_valid = 1'b1; s_data = 16'h0A01;
    next_cycle();
    s_data = 16'h0A02;
    next_cycle();
    s_valid = 1'b0;
    repeat (8) next_cycle();
    @(negedge clk);
    check("err_before", err, 0);
    check("err_occ_before", {29'h0, dut.u_fifo.occ_q}, 2);
    next_cycle();
    spur_v = 1'b1; spur_d = 16'hDEAD;
    next_cycle();
    spur_v = 1'b0;
    @(negedge clk);
    check("err_set", err, 1);
    check("err_occ_after", {29'h0, dut.u_fifo.occ_q}, 2);
    check("err_head", m_data, 32'h0A01);
    repeat (3) next_cycle();
    check("err_sticky", err, 1);
    drain();

    // Simultaneous write and pop at occ=1.
    m_ready = 1'b0; s_valid = 1'b1; s_data = 16'h0B01;
    next_cycle();
    s_data = 16'h0B02;
    next_cycle();
    s_valid = 1'b0;
    repeat (3) next_cycle();
    m_ready = 1'b1;
    @(negedge clk);
    check("wp_ret_valid", ret_valid, 1);
    check("wp_occ_before", {29'h0, dut.u_fifo.occ_q}, 1);
    next_cycle();
    m_ready = 1'b0;
    @(negedge clk);
    check("wp_occ_after", {29'h0, dut.u_fifo.occ_q}, 1);
    check("wp_head", m_data, 32'h0B02);
    next_cycle();
    drain();

    // Reset with 3 in flight and 2 buffered.
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = 16'h0C00 + 16'(i);
      next_cycle();
    end
    s_valid = 1'b0;
    next_cycle();
    @(negedge clk);
    check("mid_occ", {29'h0, dut.u_fifo.occ_q}, 2);
    check("mid_inflight", {29'h0, dut.inflight_q}, 3);
    next_cycle();
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_m_valid", m_valid, 0);
    check("midrst_s_ready", s_ready, 1);
    check("midrst_err", err, 0);
`ifdef PIPE_CREDIT_BUF_STATS_EN
    check("midrst_stall_cnt", stall_cnt, 0);
`endif
    repeat (2) next_cycle();
    rst_n = 1'b1;
    m_ready = 1'b1;
    n_mv = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (m_valid) n_mv++;
      next_cycle();
    end
    check("post_rst_outputs", n_mv, 0);

    // Stall statistics: 6 issues then 10 stalled cycles.
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1; s_data = 16'h0D00 + 16'(i);
      next_cycle();
    end
    s_valid = 1'b0;
    @(negedge clk);
    check("stats_s_ready_low", s_ready, 0);
`ifdef PIPE_CREDIT_BUF_STATS_EN
    check("stats_stall_cnt", stall_cnt, 10);
`endif
    next_cycle();
    drain();
    check("sb_empty_end", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_pipe_credit_buf
